shift_reg_sequencer: RTL and testbench
======================================

# shift_reg_sequencer

Command-driven controller for the 4-bit shifting register. It accepts one operation at a time over a valid/ready handshake: parallel load, serial shift or rotate for N clocks. It drives the register's ENB/DIR/MODO/S_IN/D inputs cycle by cycle, captures the bits leaving on S_OUT, and reports the final Q with a one-cycle DONE pulse. It sits between a host/test sequencer and the register, so multi-step register stimulus becomes single commands.

## Interface
- SER_W, 16: max shift count; width of the serial-in and capture words.
- CNT_W, 5: width of CMD_CNT; must hold SER_W.
- CLK  in  1  rising-edge clock, shared with the register.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  2  operation: 00 LOAD, 01 SHIFT, 10 ROTATE, 11 LOAD_SHIFT.
- CMD_DIR  in  1  shift direction: 0 = left, 1 = right. Forwarded to DIR.
- CMD_CNT  in  CNT_W  number of shift/rotate clocks, 0..SER_W.
- CMD_DATA  in  4  parallel load word.
- CMD_SER  in  SER_W  serial-in bits, LSB first.
- ENB, DIR, S_IN  out  1 each  register controls.
- MODO  out  2  register mode: 00 shift, 01 rotate, 10 parallel load.
- D  out  4  register parallel input.
- Q  in  4  register state.
- S_OUT  in  1  register serial output (bit leaving on the next enabled shift).
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  4  Q sampled in the DONE cycle; held until the next DONE.
- SER_CAP  out  SER_W  captured S_OUT bits; bit i = i-th shifted-out bit; upper bits 0.
- ABORT  in  1  only when SHIFT_SEQ_ABORT_EN is defined.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: CMD_READY=1, ENB=0. On CMD_VALID&CMD_READY, latch all CMD_* fields.
  - Counts above SER_W saturate to SER_W.
  - Next state: LOAD for LOAD or LOAD_SHIFT, otherwise SHIFT. SHIFT or ROTATE with count 0 goes to DONE.
- LOAD (one cycle): ENB=1, MODO=10, D=latched data.
  - Next state: SHIFT for LOAD_SHIFT with count > 0, otherwise DONE.
- SHIFT: ENB=1, DIR=latched dir. MODO=01 for ROTATE, 00 otherwise.
  - S_IN = CMD_SER bit k, where k is the 0-based shift index. S_IN is 0 in ROTATE.
  - Each cycle, capture S_OUT into SER_CAP bit k and increment k.
  - After cnt cycles, go to DONE.
- DONE (one cycle): ENB=0, DONE=1, RESULT<=Q. Then IDLE.
- CMD_READY is 0 outside IDLE. Commands presented then are not accepted and stay pending.
- SER_CAP clears on command accept. It is stable from the DONE cycle until the next accept.
- D holds its last value when not in LOAD. MODO is 10 whenever ENB=0.

## Timing
- Reset values: CMD_READY=1, ENB=0, DIR=0, S_IN=0, MODO=10, D=0000, DONE=0, RESULT=0000, SER_CAP=0. State is IDLE.
- Command accepted at edge t. Controls are registered and appear in cycle t+1.
- The register acts on the edge closing each ENB=1 cycle.
- DONE cycle for each operation:
  - LOAD: t+2.
  - SHIFT or ROTATE with n>0: t+n+1.
  - LOAD_SHIFT with n>0: t+n+2.
  - Count 0 (SHIFT or ROTATE): t+1.
  - LOAD_SHIFT with n=0 behaves as LOAD.
- Back-to-back commands: next accept is possible at the edge ending the IDLE cycle after DONE. Minimum command spacing is latency+1 cycles.
- RST has priority over everything. Mid-operation it returns to IDLE with all outputs at reset values and no DONE. The register is left frozen in whatever state it reached.

## Configuration
- SHIFT_SEQ_ABORT_EN defined:
  - ABORT input exists. ABORT=1 in LOAD or SHIFT sends the next state to DONE (ENB=0 next cycle).
  - DONE still pulses, with RESULT=Q and SER_CAP holding only the bits captured so far.
  - ABORT is ignored in IDLE and DONE.
- Not defined: no ABORT port; operations always run to completion.

## Test plan
- Reset, then LOAD 0010 accepted at cycle 0: ENB=1 with MODO=10 in cycle 1; DONE in cycle 2; RESULT=0010.
- LOAD_SHIFT data=1111, dir=left, cnt=4, CMD_SER=0: four ENB cycles with MODO=00; RESULT=0000; SER_CAP=000F; DONE at t+6.
- ROTATE cnt=4 after loading 0110: RESULT=0110; SER_CAP low nibble holds the rotated-out bits (per DIR); S_IN stays 0.
- SHIFT cnt=0: DONE at t+1, no ENB pulse. SHIFT cnt=20: saturates to 16 ENB cycles.
- CMD_VALID held high through an operation: exactly one accept per IDLE. RST asserted in the 2nd SHIFT cycle: next cycle ENB=0, CMD_READY=1, no DONE.
- With SHIFT_SEQ_ABORT_EN: ABORT in the 3rd shift cycle of cnt=8 gives DONE the next cycle, SER_CAP bits 3..15 = 0, and 3 register shifts in total.

Source files
------------

// File: rtl/shift_reg_sequencer_if.sv
// Command channel between a host/test sequencer and shift_reg_sequencer.
// Valid/ready handshake plus the operation fields latched on accept.
interface shift_reg_sequencer_if #(
  parameter int SER_W = 16,
  parameter int CNT_W = 5
);
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic             dir;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       data;
  logic [SER_W-1:0] ser;

  modport master (output valid, op, dir, cnt, data, ser, input ready);
  modport slave  (input valid, op, dir, cnt, data, ser, output ready);
endinterface

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for a 4-bit shifting register.
// Turns LOAD / SHIFT / ROTATE / LOAD_SHIFT commands into cycle-by-cycle
// ENB/DIR/MODO/S_IN/D stimulus, captures S_OUT, and reports final Q with DONE.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the abort input.
//
// state    | meaning
// ST_IDLE  | ready for a command, register idle
// ST_LOAD  | one parallel-load cycle (MODO=10)
// ST_SHIFT | shift/rotate cycles, one per shift index k
// ST_DONE  | one-cycle completion pulse, RESULT captures Q
module shift_reg_sequencer #(
  parameter int SER_W = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_reg_sequencer_if.slave cmd,
  output logic                 enb,
  output logic                 dir,
  output logic                 s_in,
  output logic [1:0]           modo,
  output logic [3:0]           d,
  input  logic [3:0]           q,
  input  logic                 s_out,
  output logic                 done,
  output logic [3:0]           result,
  output logic [SER_W-1:0]     ser_cap
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  input  logic                 abort
`endif
);
  localparam int K_W = (SER_W > 1) ? $clog2(SER_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SER_W);

  localparam logic [1:0] OP_LOAD       = 2'b00;
  localparam logic [1:0] OP_SHIFT      = 2'b01;
  localparam logic [1:0] OP_ROTATE     = 2'b10;
  localparam logic [1:0] OP_LOAD_SHIFT = 2'b11;

  localparam logic [1:0] MODO_SHIFT  = 2'b00;
  localparam logic [1:0] MODO_ROTATE = 2'b01;
  localparam logic [1:0] MODO_LOAD   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_r;
  logic             dir_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       d_r;
  logic [SER_W-1:0] ser_r;
  logic [K_W-1:0]   k_r;
  logic [3:0]       result_r;

  logic             accept;
  logic             abort_req;
  logic             last_shift;
  logic             cmd_is_load;
  logic [CNT_W-1:0] cnt_sat;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign accept      = (state == ST_IDLE) && cmd.valid;
  assign cmd_is_load = (cmd.op == OP_LOAD) || (cmd.op == OP_LOAD_SHIFT);
  assign cnt_sat     = (cmd.cnt > CNT_MAX) ? CNT_MAX : cmd.cnt;
  assign last_shift  = (CNT_W'(k_r) == (cnt_r - CNT_W'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd.valid) begin
          if (cmd_is_load)          state_nxt = ST_LOAD;
          else if (cnt_sat == '0)   state_nxt = ST_DONE;
          else                      state_nxt = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        if (abort_req || (op_r != OP_LOAD_SHIFT) || (cnt_r == '0)) state_nxt = ST_DONE;
        else                                                      state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort_req || last_shift) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Register controls and handshake decoded from the current state.
  always_comb begin
    cmd.ready = 1'b0;
    enb       = 1'b0;
    modo      = MODO_LOAD;
    s_in      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  cmd.ready = 1'b1;
      ST_LOAD:  enb = 1'b1;
      ST_SHIFT: begin
        enb = 1'b1;
        if (op_r == OP_ROTATE) begin
          modo = MODO_ROTATE;
        end else begin
          modo = MODO_SHIFT;
          s_in = ser_r[k_r];
        end
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  assign dir = dir_r;
  assign d   = d_r;
  // Q is live during the DONE pulse, then held until the next DONE.
  assign result = (state == ST_DONE) ? q : result_r;

  // Command latch, shift index, S_OUT capture and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= OP_LOAD;
      dir_r    <= 1'b0;
      cnt_r    <= '0;
      d_r      <= '0;
      ser_r    <= '0;
      k_r      <= '0;
      result_r <= '0;
      ser_cap  <= '0;
    end else begin
      if (accept) begin
        op_r    <= cmd.op;
        dir_r   <= cmd.dir;
        cnt_r   <= cnt_sat;
        ser_r   <= cmd.ser;
        k_r     <= '0;
        ser_cap <= '0;
        if (cmd_is_load) d_r <= cmd.data;
      end
      if (state == ST_SHIFT) begin
        ser_cap[k_r] <= s_out;
        k_r          <= k_r + K_W'(1);
      end
      if (state == ST_DONE) result_r <= q;
    end
  end
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Self-checking bench for shift_reg_sequencer: a behavioural 4-bit register
// closes the loop, and a command-level reference model predicts results.
`timescale 1ns/1ps
module tb_shift_reg_sequencer;
  localparam int SER_W = 16;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enb, dir, s_in, done, s_out;
  logic [1:0] modo;
  logic [3:0] d, q, result;
  logic [SER_W-1:0] ser_cap;
`ifdef SHIFT_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  logic [3:0] reg_q   = 4'b0000;
  logic [3:0] exp_reg = 4'b0000;
  logic [3:0] exp_d   = 4'b0000;
  int total = 0;
  int bad = 0;
  int accepts = 0;

  shift_reg_sequencer_if #(.SER_W(SER_W), .CNT_W(CNT_W)) cmd_if ();

  shift_reg_sequencer #(.SER_W(SER_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if),
    .enb(enb), .dir(dir), .s_in(s_in), .modo(modo), .d(d),
    .q(q), .s_out(s_out), .done(done), .result(result), .ser_cap(ser_cap)
`ifdef SHIFT_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural shifting register driven by the sequencer.
  assign q     = reg_q;
  assign s_out = dir ? reg_q[0] : reg_q[3];
  always @(posedge clk) begin
    if (enb) begin
      case (modo)
        2'b10: reg_q <= d;
        2'b00: reg_q <= dir ? {s_in, reg_q[3:1]} : {reg_q[2:0], s_in};
        2'b01: reg_q <= dir ? {reg_q[0], reg_q[3:1]} : {reg_q[2:0], reg_q[3]};
        default: ;
      endcase
    end
    if (cmd_if.valid && cmd_if.ready) accepts <= accepts + 1;
  end

  // Command-level reference: final register word and shifted-out bits.
  task automatic model(input logic [1:0] op, input logic dr, input int n,
                       input logic [3:0] data, input logic [15:0] ser,
                       input logic [3:0] q_in, output logic [3:0] q_out,
                       output logic [15:0] cap);
    int v;
    int outb;
    int inb;
    v = (op == 2'b00 || op == 2'b11) ? int'(data) : int'(q_in);
    cap = 16'h0;
    if (op != 2'b00) begin
      for (int i = 0; i < n; i++) begin
        outb = dr ? (v % 2) : (v / 8);
        inb  = (op == 2'b10) ? outb : int'(ser[i]);
        v    = dr ? (v / 2 + inb * 8) : ((v * 2) % 16 + inb);
        cap[i] = outb[0];
      end
    end
    q_out = v[3:0];
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic dr,
                         input int cnt, input logic [3:0] data, input logic [15:0] ser,
                         input bit keep_valid);
    logic [3:0] rq;
    logic [15:0] exp_cap;
    logic [1:0] exp_modo;
    int n, lat, lat_seen, exp_enb, enb_seen, shift_idx, viol, c, acc0;
    bit got;
    bit is_load;
    n = (cnt > SER_W) ? SER_W : cnt;
    is_load = (op == 2'b00) || (op == 2'b11);
    model(op, dr, n, data, ser, exp_reg, rq, exp_cap);
    case (op)
      2'b00:   lat = 2;
      2'b11:   lat = (n > 0) ? n + 2 : 2;
      default: lat = (n > 0) ? n + 1 : 1;
    endcase
    exp_enb  = (is_load ? 1 : 0) + ((op != 2'b00) ? n : 0);
    exp_modo = (op == 2'b10) ? 2'b01 : 2'b00;

    total++;
    if (cmd_if.ready !== 1'b1) begin
      bad++; $display("FAIL %s ready_before: got %b want 1", name, cmd_if.ready);
    end
    cmd_if.valid = 1'b1;
    cmd_if.op    = op;
    cmd_if.dir   = dr;
    cmd_if.cnt   = CNT_W'(cnt);
    cmd_if.data  = data;
    cmd_if.ser   = ser;
    acc0 = accepts;
    @(posedge clk);
    if (!keep_valid) #1 cmd_if.valid = 1'b0;

    got = 0; lat_seen = -1; enb_seen = 0; shift_idx = 0; viol = 0; c = 0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (cmd_if.ready !== 1'b0) viol++;
      if (enb === 1'b1) begin
        enb_seen++;
        if (is_load && c == 1) begin
          if (modo !== 2'b10 || d !== data) viol++;
        end else begin
          if (modo !== exp_modo || dir !== dr) viol++;
          if (op == 2'b10) begin
            if (s_in !== 1'b0) viol++;
          end else if (s_in !== ser[shift_idx]) viol++;
          shift_idx++;
        end
      end else if (modo !== 2'b10) viol++;
      if (done === 1'b1) begin
        got = 1;
        lat_seen = c;
      end
    end
    total++;
    if (!got || lat_seen != lat) begin
      bad++; $display("FAIL %s done_latency: got %0d want %0d", name, lat_seen, lat);
    end
    total++;
    if (enb_seen != exp_enb) begin
      bad++; $display("FAIL %s enb_cycles: got %0d want %0d", name, enb_seen, exp_enb);
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL %s control_cycles: got %0d bad cycles want 0", name, viol);
    end
    total++;
    if (result !== rq) begin
      bad++; $display("FAIL %s result_at_done: got %h want %h", name, result, rq);
    end
    total++;
    if (ser_cap !== exp_cap) begin
      bad++; $display("FAIL %s ser_cap_at_done: got %h want %h", name, ser_cap, exp_cap);
    end

    @(negedge clk);
    if (is_load) exp_d = data;
    total++;
    if ({done, cmd_if.ready, enb} !== 3'b010) begin
      bad++; $display("FAIL %s after_done done/ready/enb: got %b want 010", name, {done, cmd_if.ready, enb});
    end
    total++;
    if (result !== rq || ser_cap !== exp_cap || d !== exp_d) begin
      bad++; $display("FAIL %s held_outputs: got r=%h cap=%h d=%h want r=%h cap=%h d=%h",
                      name, result, ser_cap, d, rq, exp_cap, exp_d);
    end
    total++;
    if (accepts - acc0 != 1) begin
      bad++; $display("FAIL %s accept_count: got %0d want 1", name, accepts - acc0);
    end
    exp_reg = rq;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_if.valid = 1'b0; cmd_if.op = 2'b00; cmd_if.dir = 1'b0;
    cmd_if.cnt = '0; cmd_if.data = 4'h0; cmd_if.ser = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_if.ready, enb, dir, s_in, modo, done} !== 7'b1000100) begin
      bad++; $display("FAIL reset_controls: got %b want 1000100", {cmd_if.ready, enb, dir, s_in, modo, done});
    end
    total++;
    if ({d, result, ser_cap} !== 24'h0) begin
      bad++; $display("FAIL reset_data: got d=%h r=%h cap=%h want 0", d, result, ser_cap);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    run_cmd("load_0010", 2'b00, 1'b0, 0, 4'b0010, 16'h0000, 0);
  endtask

  task automatic test_load_shift();
    run_cmd("ls_1111_left4", 2'b11, 1'b0, 4, 4'b1111, 16'h0000, 0);
    total++;
    if (result !== 4'b0000 || ser_cap !== 16'h000F) begin
      bad++; $display("FAIL ls_constants: got r=%h cap=%h want 0 000f", result, ser_cap);
    end
  endtask

  task automatic test_rotate();
    run_cmd("load_0110", 2'b00, 1'b0, 0, 4'b0110, 16'h0000, 0);
    run_cmd("rot_right4", 2'b10, 1'b1, 4, 4'h0, 16'hFFFF, 0);
    total++;
    if (result !== 4'b0110) begin
      bad++; $display("FAIL rot4_identity: got %h want 6", result);
    end
    run_cmd("rot_left3", 2'b10, 1'b0, 3, 4'h0, 16'hA5A5, 0);
  endtask

  task automatic test_count_edges();
    run_cmd("shift_cnt0", 2'b01, 1'b0, 0, 4'h0, 16'hFFFF, 0);
    run_cmd("shift_cnt20", 2'b01, 1'b1, 20, 4'h0, 16'hC3A5, 0);
    run_cmd("ls_cnt0", 2'b11, 1'b1, 0, 4'b1001, 16'hFFFF, 0);
    run_cmd("rot_cnt16", 2'b10, 1'b0, 16, 4'h0, 16'h0000, 0);
    run_cmd("ls_cnt31", 2'b11, 1'b0, 31, 4'b0101, 16'h1234, 0);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_0", 2'b11, 1'b1, 5, 4'b1010, 16'h0F0F, 1);
    run_cmd("b2b_1", 2'b01, 1'b0, 0, 4'h0, 16'h0000, 1);
    run_cmd("b2b_2", 2'b00, 1'b0, 0, 4'b0111, 16'h0000, 1);
    run_cmd("b2b_3", 2'b10, 1'b1, 2, 4'h0, 16'h0000, 0);
  endtask

  task automatic test_reset_mid();
    logic [3:0] rq;
    logic [15:0] cap;
    logic [15:0] ser;
    logic dr;
    bit seen_done;
    ser = 16'($urandom);
    dr = 1'($urandom_range(0, 1));
    model(2'b01, dr, 2, 4'h0, ser, exp_reg, rq, cap);
    cmd_if.valid = 1'b1; cmd_if.op = 2'b01; cmd_if.dir = dr;
    cmd_if.cnt = CNT_W'(8); cmd_if.ser = ser;
    @(posedge clk);
    #1 cmd_if.valid = 1'b0;
    seen_done = 0;
    @(negedge clk);
    seen_done |= (done === 1'b1);
    @(negedge clk);
    seen_done |= (done === 1'b1);
    rst = 1'b1;
    @(negedge clk);
    seen_done |= (done === 1'b1);
    total++;
    if ({enb, cmd_if.ready, modo, dir, s_in} !== 6'b011000) begin
      bad++; $display("FAIL rst_mid_controls: got %b want 011000", {enb, cmd_if.ready, modo, dir, s_in});
    end
    total++;
    if ({d, result, ser_cap} !== 24'h0) begin
      bad++; $display("FAIL rst_mid_data: got d=%h r=%h cap=%h want 0", d, result, ser_cap);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done |= (done === 1'b1);
    end
    total++;
    if (seen_done) begin
      bad++; $display("FAIL rst_mid_no_done: got done pulse want none");
    end
    total++;
    if (reg_q !== rq) begin
      bad++; $display("FAIL rst_mid_frozen_reg: got %h want %h", reg_q, rq);
    end
    exp_reg = rq;
    exp_d = 4'h0;
  endtask

`ifdef SHIFT_SEQ_ABORT_EN
  task automatic test_abort();
    logic [3:0] rq;
    logic [15:0] cap;
    logic [15:0] ser;
    ser = 16'($urandom);
    model(2'b01, 1'b1, 3, 4'h0, ser, exp_reg, rq, cap);
    cmd_if.valid = 1'b1; cmd_if.op = 2'b01; cmd_if.dir = 1'b1;
    cmd_if.cnt = CNT_W'(8); cmd_if.ser = ser;
    @(posedge clk);
    #1 cmd_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || enb !== 1'b0) begin
      bad++; $display("FAIL abort_done: got done=%b enb=%b want 1 0", done, enb);
    end
    total++;
    if (result !== rq || ser_cap !== cap || reg_q !== rq) begin
      bad++; $display("FAIL abort_data: got r=%h cap=%h reg=%h want r=%h cap=%h", result, ser_cap, reg_q, rq, cap);
    end
    @(negedge clk);
    exp_reg = rq;
  endtask
`endif

  task automatic test_random();
    logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      run_cmd("random", op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
              4'($urandom), 16'($urandom), (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_shift();
    test_rotate();
    test_count_edges();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_SEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
